// File: rtl/dmem_access_unit_if.sv
// Data-memory bus between the access unit (master) and the memory (slave).
interface dmem_access_unit_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   modport master (
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/dmem_access_unit.sv
// Multi-cycle load/store stage with ack timeout; stalls the CPU until the access resolves.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (misaligned requests fail without a bus cycle).
module dmem_access_unit #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid_i,
   input  logic              req_write_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [DATA_W-1:0] req_wdata_i,
   output logic              req_ready_o,
   output logic              stall_o,
   output logic              resp_valid_o,
   output logic [DATA_W-1:0] resp_rdata_o,
   output logic              resp_err_o,
   dmem_access_unit_if.master mem_if
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_RESP   = 2'd2;
   localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

   logic [1:0]        state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              write_q, write_d;
   logic [ADDR_W-3:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              req_ready_q, resp_valid_q, resp_err_q, mem_en_q, mem_we_q;
   logic [DATA_W-1:0] resp_rdata_q;
   logic [DATA_W-1:0] res_rdata_s;
   logic              res_err_s;
   logic              misalign_s;

`ifdef DMEM_MISALIGN_TRAP_EN
   assign misalign_s = (req_addr_i[1:0] != 2'b00);
`else
   logic lint_unused_s;
   assign misalign_s    = 1'b0;
   assign lint_unused_s = ^req_addr_i[1:0];
`endif

   // Next-state and response-value selection; res_* are nonzero only on the edge into RESP.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      write_d     = write_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      res_rdata_s = {DATA_W{1'b0}};
      res_err_s   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid_i) begin
               write_d = req_write_i;
               addr_d  = req_addr_i[ADDR_W-1:2];
               wdata_d = req_wdata_i;
               cnt_d   = 8'd0;
               if (misalign_s) begin
                  state_d   = S_RESP;
                  res_err_s = 1'b1;
               end else begin
                  state_d = S_ACCESS;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ACCESS: begin
            // An ack on the final allowed cycle still counts as success.
            if (mem_if.mem_ack) begin
               state_d     = S_RESP;
               res_rdata_s = write_q ? {DATA_W{1'b0}} : mem_if.mem_rdata;
            end else if (cnt_q == TO_LAST) begin
               state_d   = S_RESP;
               res_err_s = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, latched request and output registers, all decoded from the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= 8'd0;
         write_q      <= 1'b0;
         addr_q       <= {(ADDR_W-2){1'b0}};
         wdata_q      <= {DATA_W{1'b0}};
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= {DATA_W{1'b0}};
         resp_err_q   <= 1'b0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         write_q      <= write_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         req_ready_q  <= (state_d == S_IDLE);
         resp_valid_q <= (state_d == S_RESP);
         resp_rdata_q <= res_rdata_s;
         resp_err_q   <= res_err_s;
         mem_en_q     <= (state_d == S_ACCESS);
         mem_we_q     <= (state_d == S_ACCESS) & write_d;
      end
   end

   assign req_ready_o      = req_ready_q;
   assign resp_valid_o     = resp_valid_q;
   assign resp_rdata_o     = resp_rdata_q;
   assign resp_err_o       = resp_err_q;
   assign stall_o          = req_valid_i & ~resp_valid_q;
   assign mem_if.mem_en    = mem_en_q;
   assign mem_if.mem_we    = mem_we_q;
   assign mem_if.mem_addr  = {addr_q, 2'b00};
   assign mem_if.mem_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: directed table, hand sequences, randomized vs. model.
module tb_dmem_access_unit;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 15;

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid, req_write;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          req_ready, stall, resp_valid, resp_err;
   logic [DW-1:0] resp_rdata;

   int n_chk  = 0;
   int n_fail = 0;

   dmem_access_unit_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();

   dmem_access_unit #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid_i  (req_valid),
      .req_write_i  (req_write),
      .req_addr_i   (req_addr),
      .req_wdata_i  (req_wdata),
      .req_ready_o  (req_ready),
      .stall_o      (stall),
      .resp_valid_o (resp_valid),
      .resp_rdata_o (resp_rdata),
      .resp_err_o   (resp_err),
      .mem_if       (mem_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          ack_at;
      bit          drop;
      bit          exp_err;
      logic [31:0] exp_rdata;
      int          exp_cyc;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   // Reference outcome computed from the access rules, not from any state machine.
   function automatic void model(input bit wr, input logic [31:0] ad, input logic [31:0] rd,
                                 input int ack_at, output bit e, output logic [31:0] r,
                                 output int c);
      bit trap;
`ifdef DMEM_MISALIGN_TRAP_EN
      trap = (ad[1:0] != 2'b00);
`else
      trap = 1'b0;
`endif
      if (trap) begin
         e = 1'b1; r = 32'd0; c = 0;
      end else if (ack_at >= 1 && ack_at <= TO) begin
         e = 1'b0; r = wr ? 32'd0 : rd; c = ack_at;
      end else begin
         e = 1'b1; r = 32'd0; c = TO;
      end
   endfunction

   // Called at a falling edge with the DUT idle; returns at the falling edge of the next idle cycle.
   task automatic run_txn(input string nm, input vec_t v);
      int  cyc = 0;
      int  lat = 0;
      bit  done = 1'b0;
      bit  bus_bad = 1'b0;
      logic [31:0] exp_addr;
      exp_addr  = {v.addr[31:2], 2'b00};
      req_valid = 1'b1;
      req_write = v.wr;
      req_addr  = v.addr;
      req_wdata = v.wdata;
      #1;
      chk({nm, "/ready"}, 64'(req_ready), 64'd1);
      chk({nm, "/stall_req"}, 64'(stall), 64'd1);
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         lat++;
         if (v.drop) req_valid = 1'b0;
         if (resp_valid) begin
            done = 1'b1;
         end else if (mem_if.mem_en) begin
            cyc++;
            if (mem_if.mem_we !== v.wr || mem_if.mem_addr !== exp_addr ||
                mem_if.mem_wdata !== v.wdata || req_ready !== 1'b0) bus_bad = 1'b1;
            if (cyc == v.ack_at) begin
               mem_if.mem_ack   = 1'b1;
               mem_if.mem_rdata = v.rdata;
            end else begin
               mem_if.mem_ack   = 1'b0;
               mem_if.mem_rdata = $urandom;
            end
         end else begin
            bus_bad = 1'b1;
         end
      end
      mem_if.mem_ack = 1'b0;
      chk({nm, "/resp_seen"}, 64'(done), 64'd1);
      chk({nm, "/bus"}, 64'(bus_bad), 64'd0);
      chk({nm, "/access_cycles"}, 64'(cyc), 64'(v.exp_cyc));
      chk({nm, "/latency"}, 64'(lat), 64'(v.exp_cyc + 1));
      chk({nm, "/err"}, 64'(resp_err), 64'(v.exp_err));
      chk({nm, "/rdata"}, 64'(resp_rdata), 64'(v.exp_rdata));
      chk({nm, "/stall_resp"}, 64'(stall), 64'd0);
      req_valid = 1'b0;
      @(negedge clk);
      chk({nm, "/idle_after"}, {61'd0, req_ready, resp_valid, mem_if.mem_en}, 64'b100);
   endtask

   initial begin
      vec_t v;
      int   cyc;
      bit   seen;
      reset            = 1'b1;
      req_valid        = 1'b0;
      req_write        = 1'b0;
      req_addr         = 32'd0;
      req_wdata        = 32'd0;
      mem_if.mem_ack   = 1'b0;
      mem_if.mem_rdata = 32'd0;

      vecs[0] = '{1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1, 1'b0, 1'b0, 32'hDEADBEEF, 1};
      vecs[1] = '{1'b1, 32'h20, 32'h12345678, 32'hFFFFFFFF, 5, 1'b0, 1'b0, 32'h0, 5};
      vecs[2] = '{1'b0, 32'h30, 32'h0, 32'h11111111, 0, 1'b0, 1'b1, 32'h0, 15};
      vecs[3] = '{1'b0, 32'h40, 32'h0, 32'hCAFEF00D, 15, 1'b0, 1'b0, 32'hCAFEF00D, 15};
`ifdef DMEM_MISALIGN_TRAP_EN
      vecs[4] = '{1'b0, 32'h13, 32'h0, 32'hA5A5A5A5, 1, 1'b0, 1'b1, 32'h0, 0};
`else
      vecs[4] = '{1'b0, 32'h13, 32'h0, 32'hA5A5A5A5, 1, 1'b0, 1'b0, 32'hA5A5A5A5, 1};
`endif
      vecs[5] = '{1'b0, 32'h84, 32'h0, 32'h0BADF00D, 3, 1'b1, 1'b0, 32'h0BADF00D, 3};

      repeat (3) @(negedge clk);
      chk("reset_state", {59'd0, req_ready, resp_valid, resp_err, mem_if.mem_en, mem_if.mem_we},
          64'b10000);
      chk("reset_rdata", 64'(resp_rdata), 64'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("idle_state", {61'd0, req_ready, stall, mem_if.mem_en}, 64'b100);

      for (int i = 0; i < 6; i++) run_txn($sformatf("dir%0d", i), vecs[i]);

      // An ack while idle must not start or finish anything.
      mem_if.mem_ack = 1'b1;
      @(negedge clk);
      mem_if.mem_ack = 1'b0;
      chk("stray_ack", {61'd0, req_ready, resp_valid, mem_if.mem_en}, 64'b100);

      // Reset during the third ACCESS cycle aborts silently.
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h50;
      cyc = 0;
      for (int i = 0; i < 10 && cyc < 3; i++) begin
         @(negedge clk);
         if (mem_if.mem_en) cyc++;
      end
      chk("rst_mid/reached", 64'(cyc), 64'd3);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_mid/state", {61'd0, req_ready, resp_valid, mem_if.mem_en}, 64'b100);
      reset = 1'b0;
      req_valid = 1'b0;
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (resp_valid || mem_if.mem_en) seen = 1'b1;
      end
      chk("rst_mid/no_resp", 64'(seen), 64'd0);

      for (int i = 0; i < 40; i++) begin
         v.wr     = 1'($urandom_range(0, 1));
         v.addr   = $urandom;
         v.wdata  = $urandom;
         v.rdata  = $urandom;
         v.ack_at = $urandom_range(0, 18);
         v.drop   = ($urandom_range(0, 3) == 0);
         model(v.wr, v.addr, v.rdata, v.ack_at, v.exp_err, v.exp_rdata, v.exp_cyc);
         run_txn($sformatf("rnd%0d", i), v);
      end

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end
endmodule
